// File: rtl/rv_pkg.sv
// Shared register-file defaults and sweep FSM state encoding.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: set beats a same-cycle writeback clear; a clear
// is forwarded to the lookup ports in the same cycle, a set is not.
module regfile_sb_scoreboard #(
  parameter int unsigned NREG  = 32,
  parameter int unsigned NREAD = 2,
  parameter int unsigned AW    = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               set_en,
  input  logic [AW-1:0]      set_addr,
  input  logic               clr_en,
  input  logic [AW-1:0]      clr_addr,
  input  logic [NREAD*AW-1:0] rd_addr,
  output logic [NREAD-1:0]   rd_busy
);

  logic [NREG-1:0] busy;
  logic            clr_fwd;

  // busy[0] is only ever touched by reset, so it stays 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (set_en && set_addr == AW'(r))
          busy[r] <= 1'b1;
        else if (clr_en && clr_addr == AW'(r))
          busy[r] <= 1'b0;
      end
    end
  end

  assign clr_fwd = clr_en && !(set_en && set_addr == clr_addr);

  for (genvar p = 0; p < NREAD; p++) begin : g_lookup
    logic [AW-1:0] a;
    assign a          = rd_addr[p*AW +: AW];
    assign rd_busy[p] = busy[a] & ~(clr_fwd && clr_addr == a);
  end

endmodule

// File: rtl/regfile_sb.sv
// Decode-stage register file: NREAD combinational read ports with write-first
// bypass, one write port, post-reset clearing sweep and busy scoreboard.
module regfile_sb #(
  parameter int unsigned XLEN  = rv_pkg::XLEN,
  parameter int unsigned NREG  = rv_pkg::NREG,
  parameter int unsigned NREAD = 2,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    ready,
  input  logic [NREAD*AW-1:0]     rd_addr,
  output logic [NREAD*XLEN-1:0]   rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [XLEN-1:0]         wd,
  input  logic                    sb_set,
  input  logic [AW-1:0]           sb_addr
);

  import rv_pkg::*;

  rf_state_e       state, state_d;
  logic [AW-1:0]   ptr;
  logic [XLEN-1:0] rf [NREG];
  logic            wen;
  logic            sen;

  assign wen = ready && we && (wa != '0);
  assign sen = ready && sb_set && (sb_addr != '0);

  always_comb begin
    state_d = state;
    case (state)
      RF_INIT: if (ptr == AW'(NREG - 1)) state_d = RF_RUN;
      RF_RUN:  state_d = RF_RUN;
      default: state_d = RF_INIT;
    endcase
  end

  // ready is loaded from the next state so it rises on the edge that clears the last register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RF_INIT;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_d;
      ready <= (state_d == RF_RUN);
      if (state == RF_INIT && ptr != AW'(NREG - 1))
        ptr <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == RF_INIT)
      rf[ptr] <= '0;
    else if (wen)
      rf[wa] <= wd;
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0] a;
    assign a = rd_addr[p*AW +: AW];
    always_comb begin
      rd_data[p*XLEN +: XLEN] = '0;
      if (ready && a != '0) begin
        if (wen && wa == a)
          rd_data[p*XLEN +: XLEN] = wd;
        else
          rd_data[p*XLEN +: XLEN] = rf[a];
      end
    end
  end

  regfile_sb_scoreboard #(
    .NREG  (NREG),
    .NREAD (NREAD),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (sen),
    .set_addr (sb_addr),
    .clr_en   (wen),
    .clr_addr (wa),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized checks of regfile_sb against a behavioural array model.
module tb_regfile_sb;

  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ready;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        sb_set;
  logic [4:0]  sb_addr;

  logic        ready2;
  logic [11:0] rd_addr2;
  logic [95:0] rd_data2;
  logic [2:0]  rd_busy2;
  logic        we2;
  logic [3:0]  wa2;
  logic [31:0] wd2;
  logic        sb_set2;
  logic [3:0]  sb_addr2;

  regfile_sb dut (
    .clk(clk), .reset(reset), .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we(we), .wa(wa), .wd(wd), .sb_set(sb_set), .sb_addr(sb_addr)
  );

  regfile_sb #(.XLEN(32), .NREG(16), .NREAD(3)) dut2 (
    .clk(clk), .reset(reset), .ready(ready2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_busy(rd_busy2), .we(we2), .wa(wa2), .wd(wd2), .sb_set(sb_set2), .sb_addr(sb_addr2)
  );

  logic [31:0] mem [32];
  logic [31:0] mbusy;
  int          mcnt;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] o_d0, o_d1;
  logic        o_b0, o_b1, o_rdy;
  int          cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (mcnt < NR || a == 0) return 32'h0;
    if (we && wa == a) return wd;
    return mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (mcnt < NR || a == 0) return 1'b0;
    return mbusy[a] && !(we && wa == a && !(sb_set && sb_addr == a));
  endfunction

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic s, input logic [4:0] sa,
                     input logic [4:0] r0, input logic [4:0] r1);
    we = w; wa = a; wd = d; sb_set = s; sb_addr = sa; rd_addr = {r1, r0};
    #3;
    o_d0 = rd_data[31:0];  o_d1 = rd_data[63:32];
    o_b0 = rd_busy[0];     o_b1 = rd_busy[1];
    o_rdy = ready;
    chk("ready", {31'b0, o_rdy}, (mcnt >= NR) ? 32'd1 : 32'd0);
    chk("data0", o_d0, exp_data(r0));
    chk("data1", o_d1, exp_data(r1));
    chk("busy0", {31'b0, o_b0}, {31'b0, exp_busy(r0)});
    chk("busy1", {31'b0, o_b1}, {31'b0, exp_busy(r1)});
    @(posedge clk);
    if (mcnt >= NR) begin
      if (s && sa != 0) mbusy[sa] = 1'b1;
      if (w && a != 0) begin
        mem[a] = d;
        if (!(s && sa == a)) mbusy[a] = 1'b0;
      end
    end else begin
      mcnt++;
    end
    #1;
  endtask

  task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r0, r1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", {30'b0, rd_busy}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mbusy = '0;
    mcnt  = 0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      idle(5'd0, 5'd0);
      if (o_rdy) break;
      n++;
    end
  endtask

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 5));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    we = 0; wa = 0; wd = 0; sb_set = 0; sb_addr = 0; rd_addr = 0;
    we2 = 0; wa2 = 0; wd2 = 0; sb_set2 = 0; sb_addr2 = 0; rd_addr2 = 0;
    reset = 0;
    #1;
    do_reset();

    // 1: sweep length and cleared array
    wait_ready(cnt);
    chk("sweep_len", 32'(cnt), 32'd32);
    for (int i = 0; i < 16; i++) begin
      idle(5'(2*i), 5'(2*i+1));
      chk("clear_even", o_d0, 32'h0);
      chk("clear_odd", o_d1, 32'h0);
    end

    // 2: write-first bypass
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0);
    chk("t2_bypass", o_d0, 32'hDEADBEEF);
    idle(5'd5, 5'd5);
    chk("t2_next0", o_d0, 32'hDEADBEEF);
    chk("t2_next1", o_d1, 32'hDEADBEEF);

    // 3: x0 hardwired
    cyc(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
    chk("t3_x0_same", o_d0 | o_d1, 32'h0);
    idle(5'd0, 5'd0);
    chk("t3_x0_next", o_d0 | o_d1, 32'h0);
    chk("t3_x0_busy", {30'b0, o_b1, o_b0}, 32'h0);

    // 4: scoreboard set/clear/priority
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("t4_set_nofwd", {31'b0, o_b0}, 32'd0);
    idle(5'd7, 5'd7);
    chk("t4_busy", {31'b0, o_b0}, 32'd1);
    cyc(1'b1, 5'd7, 32'h12, 1'b0, 5'd0, 5'd7, 5'd0);
    chk("t4_clr_fwd", {31'b0, o_b0}, 32'd0);
    chk("t4_data", o_d0, 32'h12);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
    cyc(1'b1, 5'd7, 32'h34, 1'b1, 5'd7, 5'd7, 5'd0);
    chk("t4_setwrite_same", {31'b0, o_b0}, 32'd1);
    idle(5'd7, 5'd0);
    chk("t4_setwrite_next", {31'b0, o_b0}, 32'd1);
    chk("t4_setwrite_data", o_d0, 32'h34);

    // 5: three-port, 16-register instance
    chk("t5_ready2", {31'b0, ready2}, 32'd1);
    we2 = 1; wa2 = 4'd3; wd2 = 32'h33; rd_addr2 = {4'd15, 4'd3, 4'd3};
    @(posedge clk); #1;
    we2 = 1; wa2 = 4'd15; wd2 = 32'hA5;
    #3;
    chk("t5_p0", rd_data2[31:0], 32'h33);
    chk("t5_p1", rd_data2[63:32], 32'h33);
    chk("t5_p2", rd_data2[95:64], 32'hA5);
    @(posedge clk); #1;
    we2 = 0;
    #3;
    chk("t5_p2_next", rd_data2[95:64], 32'hA5);
    @(posedge clk); #1;

    // 6: reset mid-run
    cyc(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0);
    idle(5'd9, 5'd9);
    chk("t6_busy", {30'b0, o_b1, o_b0}, 32'd3);
    chk("t6_data", o_d0, 32'h55);
    rd_addr = {5'd9, 5'd9};
    do_reset();
    cyc(1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd0);
    wait_ready(cnt);
    chk("t6_sweep_len", 32'(cnt + 1), 32'd32);
    idle(5'd9, 5'd0);
    chk("t6_x9_cleared", o_d0, 32'h0);
    chk("t6_x9_notbusy", {31'b0, o_b0}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), raddr(), $urandom(),
          1'($urandom_range(0, 3) == 0), raddr(), raddr(), raddr());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
